// File: rtl/output_backprop_unit.sv
`default_nettype none
// ============================================================================
// Module   : output_backprop_unit
// Brief    : Linear output neuron. FP runs a sequential MAC forward pass,
//            BP streams dZ and the pre-update weights to the hidden neurons
//            while applying the SGD update. Optional macro: OBU_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module output_backprop_unit #(
    parameter int              N        = 3,
    parameter int              BITS     = 16,
    parameter int              FRAC     = 8,
    parameter int              LR_SHIFT = 4,
    parameter logic [BITS-1:0] W_INIT   = 16'h0100,
    parameter logic [BITS-1:0] B_INIT   = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         FP,
    input  logic                         BP,
    input  logic [N-1:0][BITS-1:0]       x,
    input  logic [BITS-1:0]              y_true,
    output logic [BITS-1:0]              y,
    output logic [BITS-1:0]              dZ_out,
    output logic [BITS-1:0]              W_out,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_out,
    output logic                         bp_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int c_IW = (N > 1) ? $clog2(N) : 1;
    localparam int c_WW = 2 * BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FWD  = 3'd1,
        S_BIAS = 3'd2,
        S_BWD  = 3'd3,
        S_BUPD = 3'd4
    } state_t;

    state_t                   r_state;
    logic [BITS-1:0]          r_w [N];
    logic [BITS-1:0]          r_b;
    logic [BITS-1:0]          r_dz;
    logic signed [2*BITS-1:0] r_acc;
    logic [c_IW-1:0]          r_idx;

    // Intermediate results are widened to c_WW so sat() sees the true value.
    function automatic logic [BITS-1:0] sat(input logic signed [c_WW-1:0] v);
`ifdef OBU_SAT_EN
        logic signed [c_WW-1:0] c_SMAX;
        logic signed [c_WW-1:0] c_SMIN;
        c_SMAX = {{(c_WW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
        c_SMIN = {{(c_WW-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
        if (v > c_SMAX)
            return BITS'(c_SMAX);
        else if (v < c_SMIN)
            return BITS'(c_SMIN);
        else
            return BITS'(v);
`else
        return BITS'(v);
`endif
    endfunction

    logic signed [BITS-1:0]   w_xi;
    logic signed [BITS-1:0]   w_wi;
    logic signed [BITS-1:0]   w_dz;
    logic signed [BITS-1:0]   w_b;
    logic signed [BITS-1:0]   w_y;
    logic signed [BITS-1:0]   w_yt;
    logic signed [2*BITS-1:0] w_fprod;
    logic signed [2*BITS-1:0] w_fterm;
    logic signed [2*BITS-1:0] w_dprod;
    logic signed [2*BITS-1:0] w_dstep;
    logic signed [BITS-1:0]   w_bstep;

    logic signed [c_WW-1:0]   w_acc_x;
    logic signed [c_WW-1:0]   w_b_x;
    logic signed [c_WW-1:0]   w_wi_x;
    logic signed [c_WW-1:0]   w_dstep_x;
    logic signed [c_WW-1:0]   w_bstep_x;
    logic signed [c_WW-1:0]   w_y_x;
    logic signed [c_WW-1:0]   w_yt_x;
    logic signed [c_WW-1:0]   w_ysum;
    logic signed [c_WW-1:0]   w_wnew;
    logic signed [c_WW-1:0]   w_bnew;
    logic signed [c_WW-1:0]   w_dznew;

    assign w_xi    = x[r_idx];
    assign w_wi    = r_w[r_idx];
    assign w_dz    = r_dz;
    assign w_b     = r_b;
    assign w_y     = y;
    assign w_yt    = y_true;

    assign w_fprod = w_xi * w_wi;
    assign w_fterm = w_fprod >>> FRAC;
    assign w_dprod = w_dz * w_xi;
    assign w_dstep = (w_dprod >>> FRAC) >>> LR_SHIFT;
    assign w_bstep = w_dz >>> LR_SHIFT;

    assign w_acc_x   = r_acc;
    assign w_b_x     = w_b;
    assign w_wi_x    = w_wi;
    assign w_dstep_x = w_dstep;
    assign w_bstep_x = w_bstep;
    assign w_y_x     = w_y;
    assign w_yt_x    = w_yt;

    assign w_ysum  = w_acc_x + w_b_x;
    assign w_wnew  = w_wi_x - w_dstep_x;
    assign w_bnew  = w_b_x - w_bstep_x;
    assign w_dznew = w_y_x - w_yt_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_idx    <= '0;
            r_dz     <= '0;
            r_b      <= B_INIT;
            for (int i = 0; i < N; i++)
                r_w[i] <= W_INIT;
            y        <= '0;
            dZ_out   <= '0;
            W_out    <= '0;
            idx_out  <= '0;
            bp_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            bp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (FP) begin
                        r_acc   <= '0;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_FWD;
                    end else if (BP) begin
                        r_dz    <= sat(w_dznew);
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_BWD;
                    end
                end
                S_FWD: begin
                    r_acc <= r_acc + w_fterm;
                    if (r_idx == c_IW'(N - 1)) begin
                        r_idx   <= '0;
                        r_state <= S_BIAS;
                    end else begin
                        r_idx <= r_idx + c_IW'(1);
                    end
                end
                // busy stays high through the done cycle
                S_BIAS: begin
                    y       <= sat(w_ysum);
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_BWD: begin
                    bp_valid   <= 1'b1;
                    idx_out    <= r_idx;
                    dZ_out     <= r_dz;
                    W_out      <= r_w[r_idx];
                    r_w[r_idx] <= sat(w_wnew);
                    if (r_idx == c_IW'(N - 1)) begin
                        r_idx   <= '0;
                        r_state <= S_BUPD;
                    end else begin
                        r_idx <= r_idx + c_IW'(1);
                    end
                end
                S_BUPD: begin
                    r_b     <= sat(w_bnew);
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_backprop_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_backprop_unit
// Brief    : Directed bench for output_backprop_unit (forward, backward,
//            arbitration, mid-phase reset, saturation/wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_backprop_unit;

    localparam int N    = 3;
    localparam int BITS = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   FP;
    logic                   BP;
    logic [N-1:0][BITS-1:0] x;
    logic [BITS-1:0]        y_true;
    logic [BITS-1:0]        y;
    logic [BITS-1:0]        dZ_out;
    logic [BITS-1:0]        W_out;
    logic [1:0]             idx_out;
    logic                   bp_valid;
    logic                   busy;
    logic                   done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [BITS-1:0] cap_w[$];
    logic [BITS-1:0] cap_dz[$];
    int              cap_idx[$];
    int              both_cnt;
    int              lat;

    always #5 clk = ~clk;

    output_backprop_unit #(
        .N(N), .BITS(BITS), .FRAC(8), .LR_SHIFT(4),
        .W_INIT(16'h0100), .B_INIT(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .FP(FP), .BP(BP), .x(x), .y_true(y_true),
        .y(y), .dZ_out(dZ_out), .W_out(W_out), .idx_out(idx_out),
        .bp_valid(bp_valid), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Waits (bounded) for done, recording every bp_valid beat seen on the way.
    task automatic wait_done(output int edges);
        cap_w.delete();
        cap_dz.delete();
        cap_idx.delete();
        both_cnt = 0;
        edges    = 1;
        if (bp_valid) begin
            cap_w.push_back(W_out);
            cap_dz.push_back(dZ_out);
            cap_idx.push_back(int'(idx_out));
        end
        while (!done && edges < 30) begin
            @(posedge clk); #1;
            edges++;
            if (bp_valid) begin
                cap_w.push_back(W_out);
                cap_dz.push_back(dZ_out);
                cap_idx.push_back(int'(idx_out));
            end
            if (bp_valid && done) both_cnt++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic run_phase(input logic fp, input logic bp, input logic [BITS-1:0] yt,
                             output int edges);
        FP = fp; BP = bp; y_true = yt;
        @(posedge clk); #1;
        FP = 1'b0; BP = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        edges = 0;
        while (!done && edges < 30) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                cap_w.delete(); cap_dz.delete(); cap_idx.delete(); both_cnt = 0;
            end
            if (bp_valid) begin
                cap_w.push_back(W_out);
                cap_dz.push_back(dZ_out);
                cap_idx.push_back(int'(idx_out));
            end
            if (bp_valid && done) both_cnt++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic set_fwd_x();
        x[0] = 16'h0100;
        x[1] = 16'h0200;
        x[2] = 16'hFF00;
    endtask

    initial begin
        rst = 1'b1; FP = 1'b0; BP = 1'b0; y_true = '0; x = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", y, 16'h0);
        check("rst_dz", dZ_out, 16'h0);
        check("rst_w", W_out, 16'h0);
        check("rst_idx", idx_out, 2'd0);
        check("rst_bpv", bp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        set_fwd_x();

        // Forward pass: 1 + 2 - 1 = 2.0
        run_phase(1'b1, 1'b0, 16'h0, lat);
        check("fwd_lat", lat, N + 1);
        check("fwd_y", y, 16'h0200);
        check("fwd_busy_in_done", busy, 1'b1);

        // Backward issued on the edge right after done
        run_phase(1'b0, 1'b1, 16'h0100, lat);
        check("bwd_lat", lat, N + 1);
        check("bwd_beats", cap_idx.size(), N);
        check("bwd_overlap", both_cnt, 0);
        for (int k = 0; k < cap_idx.size() && k < N; k++) begin
            check($sformatf("bwd_idx%0d", k), cap_idx[k], k);
            check($sformatf("bwd_dz%0d", k), cap_dz[k], 16'h0100);
            check($sformatf("bwd_w%0d", k), cap_w[k], 16'h0100);
        end
        @(posedge clk); #1;
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
        check("hold_idx", idx_out, 2'd2);

        // Updated weights F0,E0,110 and b=-0x10: 0xF0 + 0x1C0 - 0x110 - 0x10 = 0x190
        run_phase(1'b1, 1'b0, 16'h0, lat);
        check("fwd2_y", y, 16'h0190);
        @(posedge clk); #1;
        run_phase(1'b0, 1'b1, 16'h0190, lat);
        check("bwd2_beats", cap_idx.size(), N);
        if (cap_w.size() == N) begin
            check("bwd2_w0", cap_w[0], 16'h00F0);
            check("bwd2_w1", cap_w[1], 16'h00E0);
            check("bwd2_w2", cap_w[2], 16'h0110);
            check("bwd2_dz", cap_dz[0], 16'h0000);
        end

        // Reset in the middle of a backward phase
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        run_phase(1'b1, 1'b0, 16'h0, lat);
        check("pre_rst_y", y, 16'h0200);
        BP = 1'b1; y_true = 16'h0100;
        @(posedge clk); #1;
        BP = 1'b0;
        for (int k = 0; k < 10 && !(bp_valid && idx_out == 2'd1); k++) begin
            @(posedge clk); #1;
        end
        check("reach_idx1", idx_out, 2'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_bpv", bp_valid, 1'b0);
        check("midrst_y", y, 16'h0);
        run_phase(1'b1, 1'b0, 16'h0, lat);
        check("post_rst_y", y, 16'h0200);

        // FP and BP together: forward wins
        @(posedge clk); #1;
        run_phase(1'b1, 1'b1, 16'h0100, lat);
        check("arb_y", y, 16'h0200);
        check("arb_no_bp", cap_idx.size(), 0);

        // BP pulse during FWD is dropped, not queued
        @(posedge clk); #1;
        FP = 1'b1;
        @(posedge clk); #1;
        FP = 1'b0;
        @(posedge clk); #1;
        BP = 1'b1; y_true = 16'h0000;
        @(posedge clk); #1;
        BP = 1'b0;
        wait_done(lat);
        check("ign_y", y, 16'h0200);
        check("ign_no_bp", cap_idx.size(), 0);
        @(posedge clk); #1;
        check("ign_not_queued_busy", busy, 1'b0);
        check("ign_not_queued_bpv", bp_valid, 1'b0);
        run_phase(1'b1, 1'b0, 16'h0, lat);
        check("ign_weights_kept", y, 16'h0200);

        // 3 x 127.0 overflows the output word
        x[0] = 16'h7F00; x[1] = 16'h7F00; x[2] = 16'h7F00;
        @(posedge clk); #1;
        run_phase(1'b1, 1'b0, 16'h0, lat);
`ifdef OBU_SAT_EN
        check("sat_y", y, 16'h7FFF);
`else
        check("wrap_y", y, 16'h7D00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
